// File: rtl/code_breaker_pkg.sv
// rtl/code_breaker_pkg.sv - shared states, blank symbol and width helper for the code breaker
package code_breaker_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LIFE,
      TRY,
      SCORE,
      FEEDBACK,
      WIN,
      LOSE
   } state_t;

   // Symbol value reserved for an empty slot; never accepted as a guess symbol
   localparam int BLANK_SYM = 0;

   // Bits needed to hold a count from 0 to n inclusive
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/code_breaker_param_if.sv
// rtl/code_breaker_param_if.sv - player/feedback signal bundle of the code breaker
interface code_breaker_param_if #(
   parameter int SYM_W    = 3,
   parameter int CODE_LEN = 4,
   parameter int LIVES    = 3,
   parameter int PTS_W    = 2,
   parameter int ROUND_W  = 2
);
   import code_breaker_pkg::*;

   localparam int CW = cnt_w(CODE_LEN);
   localparam int LW = cnt_w(LIVES);

   logic                      start;
   logic                      breaker_is_b;
   logic [SYM_W-1:0]          sym_in;
   logic                      enter_a;
   logic                      enter_b;
   logic                      del;
   logic [CODE_LEN*SYM_W-1:0] maker_code;
   logic [PTS_W-1:0]          init_pts_a;
   logic [PTS_W-1:0]          init_pts_b;
   logic [ROUND_W-1:0]        round_in;

   logic [CODE_LEN*SYM_W-1:0] guess_code;
   logic [CW-1:0]             exact_cnt;
   logic [CW-1:0]             partial_cnt;
   logic                      feedback_valid;
   logic [LW-1:0]             lives_left;
   logic [PTS_W-1:0]          pts_a;
   logic [PTS_W-1:0]          pts_b;
   logic [ROUND_W-1:0]        round_out;
   logic                      led_proc;
   logic                      code_maker;
   logic                      pick_a;
   logic                      pick_b;
   logic                      busy;

   modport master (
      output start, breaker_is_b, sym_in, enter_a, enter_b, del,
             maker_code, init_pts_a, init_pts_b, round_in,
      input  guess_code, exact_cnt, partial_cnt, feedback_valid, lives_left,
             pts_a, pts_b, round_out, led_proc, code_maker, pick_a, pick_b, busy
   );

   modport slave (
      input  start, breaker_is_b, sym_in, enter_a, enter_b, del,
             maker_code, init_pts_a, init_pts_b, round_in,
      output guess_code, exact_cnt, partial_cnt, feedback_valid, lives_left,
             pts_a, pts_b, round_out, led_proc, code_maker, pick_a, pick_b, busy
   );

endinterface

// File: rtl/mm_scorer.sv
// rtl/mm_scorer.sv - sequential exact/partial Mastermind scorer, one guess slot per cycle
module mm_scorer
   import code_breaker_pkg::*;
#(
   parameter int SYM_W    = 3,
   parameter int CODE_LEN = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      start,
   input  logic [CODE_LEN*SYM_W-1:0] maker,
   input  logic [CODE_LEN*SYM_W-1:0] guess,
   output logic [cnt_w(CODE_LEN)-1:0] exact_cnt,
   output logic [cnt_w(CODE_LEN)-1:0] partial_cnt,
   output logic                      done
);

   localparam int CW = cnt_w(CODE_LEN);
   localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

   logic [SYM_W-1:0]    m_sym [CODE_LEN];
   logic [SYM_W-1:0]    g_sym [CODE_LEN];
   logic [CODE_LEN-1:0] eq_mask;
   logic [CW-1:0]       exact_num;

   logic                run;
   logic [IW-1:0]       idx;
   logic [CODE_LEN-1:0] gm_q;
   logic [CODE_LEN-1:0] mm_q;
   logic [CW-1:0]       exact_q;
   logic [CW-1:0]       partial_q;

   logic                active;
   logic                last;
   logic                hit;
   logic [IW-1:0]       cur_idx;
   logic [CODE_LEN-1:0] gmask;
   logic [CODE_LEN-1:0] mmask;
   logic [CODE_LEN-1:0] mm_next;
   logic [CW-1:0]       base_p;

   // Split both codes into slots (slot 0 in the MSBs) and find exact matches
   always_comb begin
      exact_num = '0;
      for (int k = 0; k < CODE_LEN; k++) begin
         m_sym[k]   = maker[(CODE_LEN-1-k)*SYM_W +: SYM_W];
         g_sym[k]   = guess[(CODE_LEN-1-k)*SYM_W +: SYM_W];
         eq_mask[k] = (m_sym[k] == g_sym[k]);
         exact_num  = exact_num + CW'(eq_mask[k]);
      end
   end

   // The start cycle works from the fresh exact mask; later cycles from the stored masks
   always_comb begin
      active  = start | run;
      cur_idx = start ? '0 : idx;
      gmask   = start ? eq_mask : gm_q;
      mmask   = start ? eq_mask : mm_q;
      base_p  = start ? '0 : partial_q;
      last    = (cur_idx == IW'(CODE_LEN - 1));
      hit     = 1'b0;
      mm_next = mmask;
      for (int k = 0; k < CODE_LEN; k++) begin
         if (!hit && !gmask[cur_idx] && !mmask[k] && (m_sym[k] == g_sym[cur_idx])) begin
            hit        = 1'b1;
            mm_next[k] = 1'b1;
         end
      end
      done = active & last;
   end

   // Slot walk: claim the lowest free maker slot for each non-exact guess slot
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         run       <= 1'b0;
         idx       <= '0;
         gm_q      <= '0;
         mm_q      <= '0;
         exact_q   <= '0;
         partial_q <= '0;
      end else if (active) begin
         idx       <= cur_idx + IW'(1);
         run       <= !last;
         gm_q      <= gmask;
         mm_q      <= mm_next;
         partial_q <= base_p + CW'(hit);
         if (start) begin
            exact_q <= exact_num;
         end
      end
   end

   assign exact_cnt   = exact_q;
   assign partial_cnt = partial_q;

endmodule

// File: rtl/code_breaker_param.sv
// rtl/code_breaker_param.sv - two-player Mastermind breaker round controller
module code_breaker_param
   import code_breaker_pkg::*;
#(
   parameter int SYM_W    = 3,
   parameter int CODE_LEN = 4,
   parameter int LIVES    = 3,
   parameter int HOLD_CYC = 4,
   parameter int PTS_W    = 2,
   parameter int ROUND_W  = 2
) (
   input  logic               clk,
   input  logic               reset,
   code_breaker_param_if.slave bus
);

   localparam int CW = cnt_w(CODE_LEN);
   localparam int LW = cnt_w(LIVES);
   localparam int TW = cnt_w(HOLD_CYC);

   state_t                    state;
   state_t                    next;
   logic [TW-1:0]             timer;
   logic                      breaker_b;
   logic [CODE_LEN*SYM_W-1:0] guess;
   logic [CW-1:0]             count;
   logic [LW-1:0]             lives;
   logic [PTS_W-1:0]          pts_a_q;
   logic [PTS_W-1:0]          pts_b_q;
   logic [ROUND_W-1:0]        round_q;

   logic                      enter_act;
   logic                      hold_done;
   logic                      first_cyc;
   logic                      all_exact;
   logic                      sc_start;
   logic                      sc_done;
   logic                      sc_clear;
   logic [CW-1:0]             exact;
   logic [CW-1:0]             partial;
   logic                      led;
   logic                      fb_valid;
   logic                      handover;
   logic                      sel_a;
   logic                      sel_b;

   assign enter_act = breaker_b ? bus.enter_b : bus.enter_a;
   assign hold_done = (timer == TW'(HOLD_CYC - 1));
   assign first_cyc = (timer == '0);
   assign all_exact = (exact == CW'(CODE_LEN));
   assign sc_clear  = (state == IDLE);

   mm_scorer #(
      .SYM_W    (SYM_W),
      .CODE_LEN (CODE_LEN)
   ) u_scorer (
      .clk         (clk),
      .reset       (reset),
      .clear       (sc_clear),
      .start       (sc_start),
      .maker       (bus.maker_code),
      .guess       (guess),
      .exact_cnt   (exact),
      .partial_cnt (partial),
      .done        (sc_done)
   );

   // State register; the timer restarts on every state change
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= next;
         timer <= (next != state) ? '0 : timer + TW'(1);
      end
   end

   // Next-state and per-state strobes
   always_comb begin
      next     = state;
      led      = 1'b0;
      fb_valid = 1'b0;
      handover = 1'b0;
      sel_a    = 1'b0;
      sel_b    = 1'b0;
      sc_start = 1'b0;
      case (state)
         IDLE:     if (bus.start) next = LIFE;
         LIFE:     if (hold_done) next = TRY;
         TRY:      if (count == CW'(CODE_LEN)) next = SCORE;
         SCORE: begin
            sc_start = first_cyc;
            if (sc_done) next = FEEDBACK;
         end
         FEEDBACK: begin
            led      = 1'b1;
            fb_valid = 1'b1;
            if (all_exact)             next = WIN;
            else if (lives == LW'(1))  next = LOSE;
            else                       next = LIFE;
         end
         WIN: begin
            led = 1'b1;
            if (first_cyc) begin
               handover = 1'b1;
               sel_a    = !breaker_b;
               sel_b    = breaker_b;
            end
            if (hold_done) next = IDLE;
         end
         LOSE: begin
            if (first_cyc) begin
               handover = 1'b1;
               sel_a    = breaker_b;
               sel_b    = !breaker_b;
            end
            if (hold_done) next = IDLE;
         end
         default:  next = IDLE;
      endcase
   end

   // Guess entry, lives, scores and round bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         breaker_b <= 1'b0;
         guess     <= '0;
         count     <= '0;
         lives     <= '0;
         pts_a_q   <= '0;
         pts_b_q   <= '0;
         round_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               lives   <= LW'(LIVES);
               guess   <= '0;
               count   <= '0;
               pts_a_q <= bus.init_pts_a;
               pts_b_q <= bus.init_pts_b;
               round_q <= bus.round_in;
               if (bus.start) breaker_b <= bus.breaker_is_b;
            end
            LIFE: begin
               guess <= '0;
               count <= '0;
            end
            TRY: begin
               if (count != CW'(CODE_LEN)) begin
                  if (bus.del) begin
                     if (count != '0) begin
                        guess <= guess >> SYM_W;
                        count <= count - CW'(1);
                     end
                  end else if (enter_act && (bus.sym_in != SYM_W'(BLANK_SYM))) begin
                     guess <= {guess[(CODE_LEN-1)*SYM_W-1:0], bus.sym_in};
                     count <= count + CW'(1);
                  end
               end
            end
            FEEDBACK: if (!all_exact) lives <= lives - LW'(1);
            WIN, LOSE: begin
               if (first_cyc) begin
                  round_q <= round_q + ROUND_W'(1);
                  if (sel_a && (pts_a_q != '1)) pts_a_q <= pts_a_q + PTS_W'(1);
                  if (sel_b && (pts_b_q != '1)) pts_b_q <= pts_b_q + PTS_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.guess_code     = guess;
   assign bus.exact_cnt      = exact;
   assign bus.partial_cnt    = partial;
   assign bus.feedback_valid = fb_valid;
   assign bus.lives_left     = lives;
   assign bus.pts_a          = pts_a_q;
   assign bus.pts_b          = pts_b_q;
   assign bus.round_out      = round_q;
   assign bus.led_proc       = led;
   assign bus.code_maker     = handover;
   assign bus.pick_a         = sel_a;
   assign bus.pick_b         = sel_b;
   assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_code_breaker_param.sv
// tb/tb_code_breaker_param.sv - scoreboard bench for the code breaker round controller
module tb_code_breaker_param;

   localparam int SYM_W    = 3;
   localparam int CODE_LEN = 4;
   localparam int LIVES    = 3;
   localparam int HOLD_CYC = 4;
   localparam int PTS_W    = 2;
   localparam int ROUND_W  = 2;
   localparam int PTS_MAX  = (1 << PTS_W) - 1;
   localparam int RND_MOD  = 1 << ROUND_W;

   typedef struct {
      int exact;
      int partial;
      int lives;
   } fb_t;

   typedef struct {
      int pick_a;
      int pick_b;
      int pts_a;
      int pts_b;
      int rnd;
      int lives;
      int led;
   } end_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   fb_t  fb_q[$];
   end_t end_q[$];
   logic [11:0] glist[$];
   int n_cmp = 0;
   int n_err = 0;

   code_breaker_param_if #(
      .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .LIVES(LIVES), .PTS_W(PTS_W), .ROUND_W(ROUND_W)
   ) bus ();

   code_breaker_param #(
      .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .LIVES(LIVES), .HOLD_CYC(HOLD_CYC),
      .PTS_W(PTS_W), .ROUND_W(ROUND_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: no response within cycle budget", name);
   endtask

   // Mastermind rule: total colour matches minus exact matches gives partials
   function automatic void model_score(input logic [11:0] m, input logic [11:0] g,
                                       output int e, output int p);
      int cm[8];
      int cg[8];
      int tot;
      for (int s = 0; s < 8; s++) begin
         cm[s] = 0;
         cg[s] = 0;
      end
      e = 0;
      for (int k = 0; k < CODE_LEN; k++) begin
         int ms;
         int gs;
         ms = int'(m[(CODE_LEN-1-k)*SYM_W +: SYM_W]);
         gs = int'(g[(CODE_LEN-1-k)*SYM_W +: SYM_W]);
         if (ms == gs) e++;
         cm[ms]++;
         cg[gs]++;
      end
      tot = 0;
      for (int s = 1; s < 8; s++) tot += (cm[s] < cg[s]) ? cm[s] : cg[s];
      p = tot - e;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [2:0] s, input bit ea, input bit eb, input bit d);
      @(negedge clk);
      bus.sym_in  = s;
      bus.enter_a = ea;
      bus.enter_b = eb;
      bus.del     = d;
      @(negedge clk);
      bus.enter_a = 1'b0;
      bus.enter_b = 1'b0;
      bus.del     = 1'b0;
   endtask

   task automatic start_round(input bit b);
      @(negedge clk);
      bus.breaker_is_b = b;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start        = 1'b0;
      wait_cycles(HOLD_CYC + 1);
   endtask

   task automatic enter_guess(input logic [11:0] g, input bit b);
      for (int k = 0; k < CODE_LEN; k++)
         drive(g[(CODE_LEN-1-k)*SYM_W +: SYM_W], !b, b, 1'b0);
   endtask

   task automatic wait_fb();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.feedback_valid) seen = 1'b1;
      end
      if (!seen) timeout_fail("feedback_timeout");
   endtask

   // Plays guesses from glist starting in TRY; expectations are queued before each guess
   task automatic play_guesses(input bit b, input logic [11:0] maker, input int lives_in,
                               input int ia, input int ib, input int rnd);
      int lives;
      int e;
      int p;
      int pa;
      int pb;
      bit done;
      bit win;
      bit wb;
      logic [11:0] g;
      lives = lives_in;
      pa    = ia;
      pb    = ib;
      done  = 1'b0;
      win   = 1'b0;
      while (!done && glist.size() > 0) begin
         g = glist.pop_front();
         model_score(maker, g, e, p);
         fb_q.push_back('{e, p, lives});
         if (e == CODE_LEN) begin
            done = 1'b1;
            win  = 1'b1;
         end else begin
            lives--;
            if (lives == 0) done = 1'b1;
         end
         if (done) begin
            wb = win ? b : !b;
            if (wb) pb = (pb < PTS_MAX) ? pb + 1 : pb;
            else    pa = (pa < PTS_MAX) ? pa + 1 : pa;
            end_q.push_back('{wb ? 0 : 1, wb ? 1 : 0, pa, pb, (rnd + 1) % RND_MOD,
                              lives, win ? 1 : 0});
         end
         enter_guess(g, b);
         wait_fb();
         if (!done) wait_cycles(HOLD_CYC + 1);
      end
      if (done) begin
         wait_cycles(HOLD_CYC);
         check("hold_busy", int'(bus.busy), 1);
         wait_cycles(1);
         check("back_to_idle", int'(bus.busy), 0);
      end
   endtask

   task automatic play_round(input bit b, input logic [11:0] maker, input int ia,
                             input int ib, input int rnd);
      bus.maker_code = maker;
      bus.init_pts_a = PTS_W'(ia);
      bus.init_pts_b = PTS_W'(ib);
      bus.round_in   = ROUND_W'(rnd);
      wait_cycles(2);
      start_round(b);
      play_guesses(b, maker, LIVES, ia, ib, rnd);
   endtask

   // Monitor: compares feedback and handover events against queued expectations
   initial begin
      fb_t  fe;
      end_t ee;
      forever begin
         @(negedge clk);
         if (!reset && bus.feedback_valid) begin
            if (fb_q.size() == 0) begin
               timeout_fail("unexpected_feedback");
            end else begin
               fe = fb_q.pop_front();
               check("fb_exact", int'(bus.exact_cnt), fe.exact);
               check("fb_partial", int'(bus.partial_cnt), fe.partial);
               check("fb_lives", int'(bus.lives_left), fe.lives);
               check("fb_led", int'(bus.led_proc), 1);
            end
         end
         if (!reset && bus.code_maker) begin
            if (end_q.size() == 0) begin
               timeout_fail("unexpected_handover");
            end else begin
               ee = end_q.pop_front();
               check("pick_a", int'(bus.pick_a), ee.pick_a);
               check("pick_b", int'(bus.pick_b), ee.pick_b);
               check("end_led", int'(bus.led_proc), ee.led);
               @(negedge clk);
               check("handover_one_cycle", int'(bus.code_maker), 0);
               check("pts_a", int'(bus.pts_a), ee.pts_a);
               check("pts_b", int'(bus.pts_b), ee.pts_b);
               check("round_out", int'(bus.round_out), ee.rnd);
               check("end_lives", int'(bus.lives_left), ee.lives);
            end
         end
      end
   end

   initial begin
      int e;
      int p;
      logic [11:0] m;
      logic [11:0] g;
      bus.start        = 1'b0;
      bus.breaker_is_b = 1'b0;
      bus.sym_in       = '0;
      bus.enter_a      = 1'b0;
      bus.enter_b      = 1'b0;
      bus.del          = 1'b0;
      bus.maker_code   = 12'o1234;
      bus.init_pts_a   = 2'd2;
      bus.init_pts_b   = 2'd1;
      bus.round_in     = 2'd1;

      // Reset state
      wait_cycles(3);
      check("rst_guess", int'(bus.guess_code), 0);
      check("rst_exact", int'(bus.exact_cnt), 0);
      check("rst_partial", int'(bus.partial_cnt), 0);
      check("rst_lives", int'(bus.lives_left), 0);
      check("rst_pts_a", int'(bus.pts_a), 0);
      check("rst_pts_b", int'(bus.pts_b), 0);
      check("rst_round", int'(bus.round_out), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_fbv", int'(bus.feedback_valid), 0);
      check("rst_led", int'(bus.led_proc), 0);
      check("rst_code_maker", int'(bus.code_maker), 0);
      reset = 1'b0;
      wait_cycles(1);
      check("idle_lives", int'(bus.lives_left), LIVES);
      check("idle_pts_a", int'(bus.pts_a), 2);
      check("idle_pts_b", int'(bus.pts_b), 1);
      check("idle_round", int'(bus.round_out), 1);

      // Straight win by A
      glist = '{12'o1234};
      play_round(1'b0, 12'o1234, 0, 0, 0);

      // All partial, then win
      glist = '{12'o4321, 12'o1234};
      play_round(1'b0, 12'o1234, 1, 2, 2);

      // Repeated symbols, B breaks
      glist = '{12'o1211, 12'o1122};
      play_round(1'b1, 12'o1122, 0, 0, 0);

      // B loses all lives; A scores, then saturation
      glist = '{12'o5555, 12'o6666, 12'o7777};
      play_round(1'b1, 12'o1234, 1, 0, 1);
      glist = '{12'o5671, 12'o4444, 12'o2143};
      play_round(1'b1, 12'o1234, 3, 0, 2);

      // Guess editing in TRY
      bus.maker_code = 12'o1234;
      bus.init_pts_a = '0;
      bus.init_pts_b = '0;
      bus.round_in   = '0;
      wait_cycles(2);
      start_round(1'b0);
      drive(3'd0, 1'b1, 1'b0, 1'b0);
      check("blank_ignored", int'(bus.guess_code), 0);
      drive(3'd0, 1'b0, 1'b0, 1'b1);
      check("del_at_zero", int'(bus.guess_code), 0);
      drive(3'd5, 1'b1, 1'b0, 1'b0);
      drive(3'd6, 1'b1, 1'b0, 1'b0);
      drive(3'd0, 1'b0, 1'b0, 1'b1);
      drive(3'd7, 1'b1, 1'b0, 1'b0);
      check("edit_57", int'(bus.guess_code), int'(12'o0057));
      drive(3'd3, 1'b1, 1'b0, 1'b1);
      check("del_wins", int'(bus.guess_code), int'(12'o0005));
      drive(3'd4, 1'b0, 1'b1, 1'b0);
      check("other_enter_ignored", int'(bus.guess_code), int'(12'o0005));
      drive(3'd2, 1'b1, 1'b0, 1'b0);
      drive(3'd3, 1'b1, 1'b0, 1'b0);
      check("edit_523", int'(bus.guess_code), int'(12'o0523));
      model_score(12'o1234, 12'o5234, e, p);
      fb_q.push_back('{e, p, LIVES});
      drive(3'd4, 1'b1, 1'b0, 1'b0);
      wait_fb();
      wait_cycles(HOLD_CYC + 1);
      glist = '{12'o1234};
      play_guesses(1'b0, 12'o1234, LIVES - 1, 0, 0, 0);

      // Round counter wrap
      glist = '{12'o1234};
      play_round(1'b0, 12'o1234, 0, 0, 3);

      // Reset during SCORE aborts the round
      bus.maker_code = 12'o1234;
      bus.init_pts_a = 2'd2;
      bus.round_in   = 2'd1;
      wait_cycles(2);
      start_round(1'b0);
      enter_guess(12'o1234, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_guess", int'(bus.guess_code), 0);
      check("abort_exact", int'(bus.exact_cnt), 0);
      check("abort_partial", int'(bus.partial_cnt), 0);
      check("abort_lives", int'(bus.lives_left), 0);
      check("abort_pts_a", int'(bus.pts_a), 0);
      check("abort_round", int'(bus.round_out), 0);
      reset = 1'b0;
      glist = '{12'o4321, 12'o1234};
      play_round(1'b0, 12'o1234, 2, 0, 1);

      // Randomised rounds
      for (int r = 0; r < 12; r++) begin
         bit b;
         b = 1'(($urandom_range(0, 1)));
         for (int k = 0; k < CODE_LEN; k++)
            m[(CODE_LEN-1-k)*SYM_W +: SYM_W] = 3'($urandom_range(1, 7));
         glist = {};
         for (int i = 0; i < LIVES; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               g = m;
            end else begin
               for (int k = 0; k < CODE_LEN; k++)
                  g[(CODE_LEN-1-k)*SYM_W +: SYM_W] = 3'($urandom_range(1, 7));
            end
            glist.push_back(g);
         end
         play_round(b, m, int'($urandom_range(0, PTS_MAX)), int'($urandom_range(0, PTS_MAX)),
                    int'($urandom_range(0, RND_MOD - 1)));
      end

      wait_cycles(5);
      check("fb_queue_drained", fb_q.size(), 0);
      check("end_queue_drained", end_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/code_breaker_param.md
Name: code_breaker_param

Overview:
Parametrised successor of the two-player Mastermind code-breaker FSM.
- Collects a CODE_LEN-symbol guess from the active breaker (A or B) and scores it against the codemaker's code.
- Scoring gives exact (right symbol, right slot) and partial (right symbol, wrong slot) counts, computed sequentially.
- Tracks lives, awards round points and hands the codemaker role to the next player.
- Sits between the input debouncers / active-player logic and the LED/7-seg feedback drivers.

Parameters:
SYM_W, 3, bits per symbol; symbol value 0 is the blank '-' and is never a legal guess symbol
CODE_LEN, 4, symbols per code
LIVES, 3, guesses allowed per round (1..7)
HOLD_CYC, 4, cycles spent in each display/hold state
PTS_W, 2, score width per player
ROUND_W, 2, round counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a breaker round (sampled in IDLE only)
breaker_is_b  in  1  0 = A breaks, 1 = B breaks; latched on start
sym_in  in  SYM_W  symbol switches
enter_a  in  1  single-cycle debounced enter pulse, player A
enter_b  in  1  single-cycle debounced enter pulse, player B
del  in  1  single-cycle pulse; erase last entered symbol
maker_code  in  CODE_LEN*SYM_W  codemaker's code; slot 0 in MSBs
init_pts_a  in  PTS_W  score of A loaded in IDLE
init_pts_b  in  PTS_W  score of B loaded in IDLE
round_in  in  ROUND_W  round count loaded in IDLE
guess_code  out  CODE_LEN*SYM_W  guess being built; new symbol shifts in at LSBs
exact_cnt  out  clog2(CODE_LEN+1)  exact matches of last scored guess
partial_cnt  out  clog2(CODE_LEN+1)  partial matches of last scored guess
feedback_valid  out  1  high in FEEDBACK
lives_left  out  clog2(LIVES+1)  remaining lives
pts_a  out  PTS_W  score A
pts_b  out  PTS_W  score B
round_out  out  ROUND_W  updated round count
led_proc  out  1  request LED feedback display
code_maker  out  1  one-cycle handover pulse
pick_a  out  1  with code_maker: A becomes codemaker
pick_b  out  1  with code_maker: B becomes codemaker
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, high at posedge): state = IDLE, timer = 0. All outputs are 0 at the next edge, including counts, scores, round and guess. Reset mid-round aborts with no point or round update.
- IDLE: each cycle lives_left <= LIVES, guess/counts cleared, pts_a/pts_b <= init_pts_a/init_pts_b, round_out <= round_in. On start, latch breaker_is_b and go to LIFE.
- LIFE: clears guess and symbol count, then holds HOLD_CYC cycles before going to TRY.
- TRY: only the active player's enter is honoured.
  - enter with sym_in != 0 and count < CODE_LEN: guess <= {guess[(CODE_LEN-1)*SYM_W-1:0], sym_in}, count++.
  - enter with sym_in == 0: ignored.
  - del with count > 0: guess >>= SYM_W, count--.
  - del and enter in the same cycle: del wins.
  - When count == CODE_LEN, go to SCORE on the next edge.
- SCORE: runs exactly CODE_LEN cycles, one guess slot per cycle.
  - Cycle 0 computes exact_cnt and the exact-matched mask for both codes.
  - Cycle j handles guess slot j; if it is not an exact match, it claims the lowest-index unmatched maker slot with an equal symbol and partial_cnt++.
  - Counts are stable from the FEEDBACK cycle onward. exact + partial <= CODE_LEN always.
- FEEDBACK (1 cycle): led_proc = 1, feedback_valid = 1.
  - exact_cnt == CODE_LEN: go to WIN (no life lost).
  - Otherwise lives_left--; go to LOSE if it becomes 0, else LIFE.
- WIN (HOLD_CYC cycles, led_proc = 1) and LOSE (HOLD_CYC cycles):
  - First cycle only: code_maker = 1 plus one pick output. WIN: pick of the breaker. LOSE: pick of the opponent.
  - First cycle only: that same player's points increment, saturating at 2^PTS_W-1.
  - First cycle only: round_out increments and wraps modulo 2^ROUND_W.
  - Then return to IDLE.
- start or enter/del outside their own states is ignored.
- maker_code must be stable while busy.

Decomposition:
- Shared package code_breaker_pkg: state enum {IDLE, LIFE, TRY, SCORE, FEEDBACK, WIN, LOSE}, the blank-symbol constant, and a width helper function for the count and lives widths.
- One natural sub-module, mm_scorer: a sequential exact/partial scorer with start/done, parametrised on SYM_W and CODE_LEN.

Test Plan:
- Defaults; maker 1-2-3-4; A breaks; enters 1,2,3,4 -> exact = 4, partial = 0, WIN. On the first WIN cycle: code_maker and pick_a high one cycle, pts_a 0→1, round_out 0→1, idle after 4 hold cycles.
- Maker 1-2-3-4; guess 4-3-2-1 -> exact = 0, partial = 4, lives 3→2, back to LIFE. Maker 1-1-2-2, guess 1-2-1-1 -> exact = 1, partial = 2.
- B breaks; three wrong guesses -> lives 3→2→1→0, LOSE: pts_a++, pick_a pulse, pick_b stays 0, round_out++. With init_pts_a = 3: pts_a stays 3 (saturation).
- TRY: sym_in = 0 with enter ignored; del at count 0 ignored; enter 5, 6, del, 7 -> guess low bits = 5,7 with count 2. del + enter in the same cycle -> count decrements only.
- enter_b pulses while A breaks -> no effect. round_in = 3 plus a win -> round_out = 0 (wrap).
- Reset asserted mid-SCORE -> next edge IDLE with all outputs 0. A following start runs normally with lives_left = 3.
